// File: rtl/core_hlink_rx_fifo.sv
// rtl/core_hlink_rx_fifo.sv - receive-side elastic buffer for the core-to-core activation link
//
// Purpose: captures every word the upstream link register presents (no
// backpressure) into a small FIFO. It hands words to the local activation
// consumer over a show-ahead valid/ready handshake. Dropped words raise a
// sticky overflow flag, and an almost-full hint lets the scheduler throttle
// the sending core.
//
// Ports:
//   clk           system clock, all logic on rising edge
//   rst           synchronous active-high reset
//   hlink_rdata   link word from upstream core
//   hlink_rvalid  word valid this cycle; cannot be stalled
//   act_rdata     head-of-FIFO word to local core (0 when empty)
//   act_rvalid    act_rdata holds a valid word
//   act_rready    local core accepts act_rdata this cycle
//   fifo_cnt      current occupancy
//   afull         fifo_cnt >= AFULL_TH
//   overflow      sticky: a link word was dropped
//   ovf_clr       clears overflow (a same-cycle drop wins)

module core_hlink_rx_fifo #(
  parameter int CACHE_DATA_WIDTH = 32,
  parameter int DEPTH            = 4,
  parameter int AFULL_TH         = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CACHE_DATA_WIDTH-1:0]  hlink_rdata,
  input  logic                         hlink_rvalid,
  output logic [CACHE_DATA_WIDTH-1:0]  act_rdata,
  output logic                         act_rvalid,
  input  logic                         act_rready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic                         afull,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH_C = CW'(AFULL_TH);

  logic [CACHE_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign pop   = act_rvalid & act_rready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the word.
  assign push  = hlink_rvalid & (~full | pop);
  assign drop  = hlink_rvalid & full & ~pop;

  // Outputs derive only from registered state; gating the read data with
  // empty keeps act_rdata at zero after reset even though mem is not reset.
  assign act_rvalid = ~empty;
  assign act_rdata  = empty ? '0 : mem[rd_ptr];
  assign fifo_cnt   = cnt;
  assign afull      = (cnt >= AFULL_TH_C);

  // Storage array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= hlink_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/core_hlink_rx_fifo.md
Name: core_hlink_rx_fifo

Overview:
Receive-side elastic buffer for the core-to-core activation link. It captures every word the upstream core's link register presents (data plus single-cycle valid, no backpressure) and holds it in a small FIFO. It then hands words to the local core's activation consumer over a valid/ready handshake. Overflow is flagged sticky, and an almost-full hint is provided so the scheduler can throttle the sending core.

Parameters:
CACHE_DATA_WIDTH, `MAC_MULT_NUM*`IDATA_WIDTH, width of one link word
DEPTH, 4, FIFO entries; power of two, >= 2
AFULL_TH, DEPTH-1, occupancy at or above which afull asserts; 1..DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
hlink_rdata  input  CACHE_DATA_WIDTH  link word from upstream core
hlink_rvalid  input  1  word valid this cycle; cannot be stalled
act_rdata  output  CACHE_DATA_WIDTH  head-of-FIFO word to local core
act_rvalid  output  1  act_rdata holds a valid word
act_rready  input  1  local core accepts act_rdata this cycle
fifo_cnt  output  $clog2(DEPTH+1)  current occupancy
afull  output  1  fifo_cnt >= AFULL_TH
overflow  output  1  sticky: a link word was dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset: synchronous, active-high; clk is the only clock.
- Reset values: wr_ptr=0, rd_ptr=0, fifo_cnt=0, act_rvalid=0, act_rdata=0, afull=0 (AFULL_TH>=1), overflow=0.
- Storage array contents are not reset.
- Reset asserted mid-stream discards all stored words. A word presented in the reset cycle is not captured.
- Storage: DEPTH-entry register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping naturally (DEPTH-1 -> 0). fifo_cnt tracks occupancy explicitly.
- push = hlink_rvalid & (~full | pop), where full = (fifo_cnt==DEPTH).
- pop = act_rvalid & act_rready.
- Output is show-ahead:
  - act_rdata = mem[rd_ptr], act_rvalid = (fifo_cnt!=0), both registered-state derived (no combinational path from hlink_* to act_*).
  - Latency: word pushed at edge N is visible on act_rdata/act_rvalid after edge N, i.e. in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop:
  - Both pointers advance and fifo_cnt is unchanged.
  - Allowed when full: the popped slot is freed and the new word is written the same edge, with no drop.
  - When empty, pop is impossible (act_rvalid=0), so only the push occurs.
- fifo_cnt next = cnt + push - pop. It never exceeds DEPTH and never goes below 0.
- act_rready while act_rvalid=0 is ignored: no pointer or count change.
- act_rdata must hold stable while act_rvalid=1 and act_rready=0.
- Overflow:
  - hlink_rvalid=1 while full and no pop means the word is dropped, with no pointer, count or data change.
  - overflow is set on the next edge and stays 1 until ovf_clr or rst.
  - ovf_clr and a drop in the same cycle: the set wins (overflow=1).
- afull = (fifo_cnt >= AFULL_TH), computed from the registered count, updated the same edge as fifo_cnt.
- Word order is strictly preserved and there is no duplication.

Test Plan:
- Reset/idle: assert rst for 2 cycles with hlink_rvalid=1 -> after release fifo_cnt=0, act_rvalid=0, act_rdata=0, overflow=0, afull=0; no word captured.
- Latency/pass-through (DEPTH=4): push 0xA1 at edge N with act_rready=1 held -> act_rvalid=1, act_rdata=0xA1 in cycle N+1; popped at edge N+1; fifo_cnt 0->1->0.
- Fill and stall:
  - Setup: act_rready=0; push 0x01..0x04 on consecutive cycles.
  - Expected: fifo_cnt=4, afull=1 from cnt=3, act_rdata=0x01 stable.
  - Then assert act_rready=1 for 4 cycles: outputs 0x01,0x02,0x03,0x04 in order; pointers wrap; fifo_cnt returns to 0.
- Full with simultaneous push/pop: with FIFO full, drive hlink_rvalid=1 (0x05) and act_rready=1 in the same cycle -> 0x01 popped, 0x05 stored, fifo_cnt stays 4, overflow stays 0; final drain yields 0x02,0x03,0x04,0x05.
- Overflow:
  - Setup: FIFO full, act_rready=0; push 0x66.
  - Expected: word dropped, fifo_cnt=4, overflow=1 next cycle and sticky.
  - Then drive ovf_clr=1 alone: overflow=0 next cycle.
  - Then drive ovf_clr=1 together with another drop: overflow remains 1.
- Reset mid-operation: with fifo_cnt=3 and streaming, assert rst 1 cycle -> next cycle fifo_cnt=0, act_rvalid=0; a subsequent push 0x7E appears as first output.
